// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DATA_W data bits LSB first, optional parity, 1 or 2 stops.
// Define UART_TX_BREAK_EN to add the break_req input and the BREAK line state.
module uart_tx_serializer #(
    parameter int unsigned DATA_W     = 8,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_tick,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
`ifdef UART_TX_BREAK_EN
    input  logic              break_req,
`endif
    output logic              tx_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef UART_TX_BREAK_EN
        , S_BREAK
`endif
    } state_t;

    state_t            state, state_n;
    logic              tx_out_n, ready_n, busy_n, done_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [DATA_W-1:0] data_r, data_n, sh_r, sh_n;
    logic [1:0]        pmode_r, pmode_n;
    logic              stop2_r, stop2_n;
    logic              par_en, par_bit;

`ifdef UART_TX_BREAK_EN
    localparam int unsigned BW = $clog2(DATA_W + 4);
    localparam logic [BW-1:0] BRK_LAST = BW'(DATA_W + 2);
    logic [BW-1:0] brk_cnt, brk_cnt_n;
`endif

    assign par_en  = (pmode_r == 2'b01) || (pmode_r == 2'b10);
    assign par_bit = (^data_r) ^ (pmode_r == 2'b10);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            tx_out   <= IDLE_LEVEL;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            data_r   <= '0;
            sh_r     <= '0;
            pmode_r  <= '0;
            stop2_r  <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_cnt  <= '0;
`endif
        end else begin
            state    <= state_n;
            tx_out   <= tx_out_n;
            tx_ready <= ready_n;
            busy     <= busy_n;
            done     <= done_n;
            cnt      <= cnt_n;
            data_r   <= data_n;
            sh_r     <= sh_n;
            pmode_r  <= pmode_n;
            stop2_r  <= stop2_n;
`ifdef UART_TX_BREAK_EN
            brk_cnt  <= brk_cnt_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        tx_out_n = tx_out;
        ready_n  = tx_ready;
        busy_n   = busy;
        done_n   = 1'b0;
        cnt_n    = cnt;
        data_n   = data_r;
        sh_n     = sh_r;
        pmode_n  = pmode_r;
        stop2_n  = stop2_r;
`ifdef UART_TX_BREAK_EN
        brk_cnt_n = brk_cnt;
`endif
        case (state)
            S_IDLE: begin
`ifdef UART_TX_BREAK_EN
                if (break_req) begin
                    state_n   = S_BREAK;
                    ready_n   = 1'b0;
                    busy_n    = 1'b1;
                    tx_out_n  = ~IDLE_LEVEL;
                    brk_cnt_n = '0;
                end else
`endif
                if (tx_valid && tx_ready) begin
                    state_n = S_ARM;
                    ready_n = 1'b0;
                    busy_n  = 1'b1;
                    data_n  = tx_data;
                    sh_n    = tx_data;
                    pmode_n = parity_mode;
                    stop2_n = stop2;
                end
            end
            S_ARM: if (bit_tick) begin
                state_n  = S_START;
                tx_out_n = ~IDLE_LEVEL;
            end
            S_START: if (bit_tick) begin
                state_n  = S_DATA;
                tx_out_n = sh_r[0];
                sh_n     = sh_r >> 1;
                cnt_n    = CW'(1);
            end
            // cnt holds the number of data bits already placed on the line
            S_DATA: if (bit_tick) begin
                if (cnt == LAST_BIT) begin
                    cnt_n = '0;
                    if (par_en) begin
                        state_n  = S_PARITY;
                        tx_out_n = par_bit;
                    end else begin
                        state_n  = S_STOP;
                        tx_out_n = IDLE_LEVEL;
                    end
                end else begin
                    tx_out_n = sh_r[0];
                    sh_n     = sh_r >> 1;
                    cnt_n    = cnt + 1'b1;
                end
            end
            S_PARITY: if (bit_tick) begin
                state_n  = S_STOP;
                tx_out_n = IDLE_LEVEL;
                cnt_n    = '0;
            end
            S_STOP: if (bit_tick) begin
                if (stop2_r && (cnt == '0)) begin
                    cnt_n = CW'(1);
                end else begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                    ready_n = 1'b1;
                    busy_n  = 1'b0;
                end
            end
`ifdef UART_TX_BREAK_EN
            // Release only after the minimum hold, then reuse STOP for the single idle period
            S_BREAK: if (bit_tick) begin
                if ((brk_cnt >= BRK_LAST) && !break_req) begin
                    state_n  = S_STOP;
                    tx_out_n = IDLE_LEVEL;
                    cnt_n    = '0;
                    stop2_n  = 1'b0;
                end else if (brk_cnt < BRK_LAST) begin
                    brk_cnt_n = brk_cnt + 1'b1;
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer (DATA_W=8, IDLE_LEVEL=1): frame table plus
// back-to-back and mid-frame reset sequences.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       reset, bit_tick, tx_valid, tx_ready;
    logic [7:0] tx_data;
    logic [1:0] parity_mode;
    logic       stop2, tx_out, busy, done;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    uart_tx_serializer #(.DATA_W(8), .IDLE_LEVEL(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .bit_tick    (bit_tick),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .tx_out      (tx_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  pm;
        logic        s2;
        int unsigned gap;
        logic        tick_on_xfer;
        string       bits;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        bit_tick = 1'b1;
        step();
        bit_tick = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tx_out"}, tx_out, 1'b1);
        check({tag, "_ready"}, tx_ready, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
    endtask

    // Transfer one word, then scramble the inputs so latching is exercised
    task automatic send(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                        input logic tick_same, input logic keep_valid);
        check("pre_xfer_ready", tx_ready, 1'b1);
        tx_valid    = 1'b1;
        tx_data     = d;
        parity_mode = pm;
        stop2       = s2;
        bit_tick    = tick_same;
        step();
        bit_tick    = 1'b0;
        tx_valid    = keep_valid;
        tx_data     = ~d;
        parity_mode = ~pm;
        stop2       = ~s2;
        check("arm_busy", busy, 1'b1);
        check("arm_ready", tx_ready, 1'b0);
        check("arm_tx_out", tx_out, 1'b1);
    endtask

    task automatic run_frame(input string bits, input int unsigned gap);
        logic e;
        step();
        check("arm_hold_tx_out", tx_out, 1'b1);
        for (int k = 0; k < bits.len(); k++) begin
            e = (bits.getc(k) == 8'h31);
            do_tick();
            check($sformatf("bit%0d", k), tx_out, e);
            check($sformatf("bit%0d_done", k), done, 1'b0);
            check($sformatf("bit%0d_busy", k), busy, 1'b1);
            for (int g = 0; g < int'(gap); g++) begin
                step();
                check($sformatf("bit%0d_hold", k), tx_out, e);
            end
        end
        do_tick();
        check("end_done", done, 1'b1);
        check("end_ready", tx_ready, 1'b1);
        check("end_busy", busy, 1'b0);
        check("end_tx_out", tx_out, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h55, 2'b00, 1'b0, 2, 1'b0, "0101010101"};
        vecs[1] = '{8'h07, 2'b01, 1'b1, 0, 1'b0, "011100000111"};
        vecs[2] = '{8'h07, 2'b10, 1'b1, 1, 1'b0, "011100000011"};
        vecs[3] = '{8'hA3, 2'b11, 1'b0, 3, 1'b1, "0110001011"};
        vecs[4] = '{8'h00, 2'b10, 1'b0, 0, 1'b0, "00000000011"};
        vecs[5] = '{8'hFF, 2'b01, 1'b0, 1, 1'b0, "01111111101"};

        reset = 1'b1; bit_tick = 1'b0; tx_valid = 1'b0;
        tx_data = '0; parity_mode = '0; stop2 = 1'b0;
        step();
        step();
        check_idle("reset");
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            do_tick();
            check_idle("idle_tick");
            step();
        end

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].data, vecs[i].pm, vecs[i].s2, vecs[i].tick_on_xfer, 1'b0);
            run_frame(vecs[i].bits, vecs[i].gap);
            step();
            check_idle("post_frame");
        end

        // Back-to-back: valid stays high, second word presented during the first frame
        send(8'hA3, 2'b00, 1'b0, 1'b0, 1'b1);
        tx_data = 8'h3C; parity_mode = 2'b00; stop2 = 1'b0;
        run_frame("0110001011", 1);
        step();
        check("b2b_second_busy", busy, 1'b1);
        check("b2b_second_ready", tx_ready, 1'b0);
        check("b2b_second_done", done, 1'b0);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        stop2    = 1'b1;
        run_frame("0001111001", 2);
        step();
        check_idle("b2b_after");

        // Reset while data bit 4 of an all-zero word is on the line
        send(8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            do_tick();
            step();
        end
        check("abort_bit4_low", tx_out, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle("abort_reset");
        for (int k = 0; k < 12; k++) begin
            do_tick();
            check_idle("abort_after");
        end
        send(8'h55, 2'b00, 1'b0, 1'b0, 1'b0);
        run_frame("0101010101", 1);
        step();
        check_idle("abort_recover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
